// File: rtl/pipe_arb_pkg.sv
// Shared types and constants for the pipelined round-robin arbiter.
package pipe_arb_pkg;

  // Width of each per-requester grant statistics counter.
  localparam int unsigned CntW = 16;

  // Tag id field width; supports up to 256 requesters.
  localparam int unsigned TagIdW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } arb_state_e;

  // One slot of the latency-matching tag pipeline.
  typedef struct packed {
    logic              valid;
    logic [TagIdW-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: picks the first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Scan from ptr upward, modulo NUM_REQ; the first hit wins.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = IDX_W'((32'(ptr) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx;
      end
    end
  end

endmodule

// File: rtl/pipe_arbiter.sv
// Round-robin arbiter feeding a fixed-latency datapath, routing each result
// back to its requester via a tag pipeline.
// Optional build macro PIPE_ARB_STATS_EN adds saturating per-requester
// grant counters on the grant_cnt port.
module pipe_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [DATA_W-1:0]              pipe_in,
  input  logic [DATA_W-1:0]              pipe_out,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_W-1:0]              rsp_data,
  output logic                           idle
`ifdef PIPE_ARB_STATS_EN
  , output logic [NUM_REQ-1:0][CntW-1:0] grant_cnt
`endif
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned InfW = $clog2(PIPE_LAT + 1);

  arb_state_e        state_q;
  logic              idle_q;
  logic [IdxW-1:0]   ptr_q;
  logic [InfW-1:0]   inflight_q;
  tag_t              tags_q [PIPE_LAT];

  logic              grant_en;
  logic [NUM_REQ-1:0] req_masked;
  logic [NUM_REQ-1:0] grant;
  logic [IdxW-1:0]   winner;
  logic              xfer;
  logic              rsp_fire;
  tag_t              tail;

  // Grants only while running and en is still high, so en falling blocks
  // the grant in that same cycle.
  assign grant_en   = (state_q == StRun) && en;
  assign req_masked = req_valid & {NUM_REQ{grant_en}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_rr (
    .req    (req_masked),
    .ptr    (ptr_q),
    .grant  (grant),
    .winner (winner)
  );

  assign req_ready = grant;
  assign xfer      = |grant;
  assign pipe_in   = xfer ? req_data[winner] : '0;
  assign tail      = tags_q[PIPE_LAT-1];
  assign rsp_fire  = tail.valid;
  assign rsp_data  = rsp_fire ? pipe_out : '0;
  assign idle      = idle_q;

  // Decode the tail tag into a one-hot response strobe.
  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = tail.valid && (tail.id == TagIdW'(i));
    end
  end

  // Control FSM; idle is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idle_q  <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (en) begin
            state_q <= StRun;
            idle_q  <= 1'b0;
          end
        end
        StRun: begin
          if (!en) state_q <= StDrain;
        end
        StDrain: begin
          if (inflight_q == '0) begin
            state_q <= StIdle;
            idle_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

  // Round-robin pointer: moves past the winner on each transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (xfer) begin
      ptr_q <= (winner == IdxW'(NUM_REQ - 1)) ? '0 : winner + IdxW'(1);
    end
  end

  // Tag pipeline tracks which requester owns each datapath stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < PIPE_LAT; i++) tags_q[i] <= '0;
    end else begin
      tags_q[0] <= '{valid: xfer, id: TagIdW'(winner)};
      for (int unsigned i = 1; i < PIPE_LAT; i++) tags_q[i] <= tags_q[i-1];
    end
  end

  // In-flight count; simultaneous transfer and response cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
    end else begin
      case ({xfer, rsp_fire})
        2'b10:   inflight_q <= inflight_q + InfW'(1);
        2'b01:   inflight_q <= inflight_q - InfW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

`ifdef PIPE_ARB_STATS_EN
  logic [NUM_REQ-1:0][CntW-1:0] grant_cnt_q;

  // Saturating grant counters, one per requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && (grant_cnt_q[i] != '1)) grant_cnt_q[i] <= grant_cnt_q[i] + CntW'(1);
      end
    end
  end

  assign grant_cnt = grant_cnt_q;
`else
  // Statistics disabled: no counters are built.
`endif

endmodule
